// File: rtl/cpu_defs.sv
// cpu_defs: shared register-file constants for the multicycle CPU
package cpu_defs;
  localparam int REG_IDX_W = 5;
  localparam int WORD_W = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_SP = 5'd29;
  localparam logic [REG_IDX_W-1:0] REG_RA = 5'd31;
  localparam logic [WORD_W-1:0] SP_RESET_DEFAULT = 32'd227;
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: combinational read select with zero-index override and write-through forwarding
module reg_read_port
  import cpu_defs::*;
(
  input  logic [WORD_W-1:0]    regs [32],
  input  logic [REG_IDX_W-1:0] read_reg,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic [WORD_W-1:0]    write_data,
  output logic [WORD_W-1:0]    data
);
  assign data = read_reg == REG_ZERO ? '0 :
                (reg_write && write_reg == read_reg) ? write_data : regs[read_reg];
endmodule

// File: rtl/reg_bank.sv
// reg_bank: 32x32 register file, r0 hardwired to zero, two registered forwarding read ports
module reg_bank
  import cpu_defs::*;
#(
  parameter logic [WORD_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic [WORD_W-1:0]    write_data,
  input  logic [REG_IDX_W-1:0] read_reg1,
  input  logic [REG_IDX_W-1:0] read_reg2,
  output logic [WORD_W-1:0]    read_data1,
  output logic [WORD_W-1:0]    read_data2
);
  logic [WORD_W-1:0] regs [32];
  logic [WORD_W-1:0] rd1, rd2;
  reg_read_port port1 (
    .regs(regs), .read_reg(read_reg1), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .data(rd1)
  );
  reg_read_port port2 (
    .regs(regs), .read_reg(read_reg2), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .data(rd2)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= REG_IDX_W'(i) == REG_SP ? SP_RESET : '0;
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      if (reg_write && write_reg != REG_ZERO) regs[write_reg] <= write_data;
      read_data1 <= rd1;
      read_data2 <= rd2;
    end
  end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: table-driven, hand-sequenced and randomized checks of reg_bank against an array model
module tb_reg_bank;
  logic clk = 0, reset, reg_write;
  logic [4:0] write_reg, read_reg1, read_reg2;
  logic [31:0] write_data, read_data1, read_data2;
  int checks = 0, failures = 0;
  logic [31:0] model [32];
  logic [31:0] m1, m2;

  typedef struct {
    logic rst, rw;
    logic [4:0] wr;
    logic [31:0] wd;
    logic [4:0] r1, r2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t tbl [18];

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: writes land first, then a read sees the newest value; model[0] is never written
  task automatic step(input logic rst, input logic rw, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset = rst; reg_write = rw; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2;
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 0;
      model[29] = 32'd227;
      m1 = 0; m2 = 0;
    end else begin
      if (rw && wr != 0) model[wr] = wd;
      m1 = model[r1]; m2 = model[r2];
    end
    #1;
  endtask

  initial begin
    foreach (model[i]) model[i] = 0;
    tbl[0]  = '{1, 1, 5'd3,  32'h55,        5'd29, 5'd31, 32'h0,        32'h0};
    tbl[1]  = '{0, 0, 5'd0,  32'h0,         5'd29, 5'd31, 32'd227,      32'h0};
    tbl[2]  = '{0, 1, 5'd8,  32'hDEADBEEF,  5'd0,  5'd0,  32'h0,        32'h0};
    tbl[3]  = '{0, 0, 5'd0,  32'h0,         5'd8,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[4]  = '{0, 1, 5'd31, 32'h40,        5'd0,  5'd31, 32'h0,        32'h40};
    tbl[5]  = '{0, 0, 5'd0,  32'h0,         5'd31, 5'd31, 32'h40,       32'h40};
    tbl[6]  = '{0, 1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd0,  32'h0,        32'h0};
    tbl[7]  = '{0, 0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,        32'h0};
    tbl[8]  = '{0, 1, 5'd5,  32'h11111111,  5'd0,  5'd0,  32'h0,        32'h0};
    tbl[9]  = '{0, 0, 5'd5,  32'h22222222,  5'd5,  5'd5,  32'h11111111, 32'h11111111};
    tbl[10] = '{0, 1, 5'd5,  32'h22222222,  5'd5,  5'd5,  32'h22222222, 32'h22222222};
    tbl[11] = '{0, 0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h22222222, 32'h22222222};
    tbl[12] = '{0, 0, 5'd9,  32'h12345678,  5'd9,  5'd0,  32'h0,        32'h0};
    tbl[13] = '{0, 0, 5'd0,  32'h0,         5'd9,  5'd9,  32'h0,        32'h0};
    tbl[14] = '{0, 1, 5'd29, 32'h100,       5'd29, 5'd0,  32'h100,      32'h0};
    tbl[15] = '{0, 0, 5'd0,  32'h0,         5'd29, 5'd0,  32'h100,      32'h0};
    tbl[16] = '{1, 1, 5'd3,  32'h55,        5'd29, 5'd3,  32'h0,        32'h0};
    tbl[17] = '{0, 0, 5'd0,  32'h0,         5'd29, 5'd3,  32'd227,      32'h0};
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rw, tbl[i].wr, tbl[i].wd, tbl[i].r1, tbl[i].r2);
      check($sformatf("vec%0d_rd1", i), read_data1, tbl[i].e1);
      check($sformatf("vec%0d_rd2", i), read_data2, tbl[i].e2);
    end
    // fill the whole array with distinct words, then read every index back on both ports
    for (int i = 0; i < 32; i++) step(0, 1, 5'(i), 32'hA5000000 | 32'(i * 7), 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check($sformatf("fill_rd1_%0d", i), read_data1, i == 0 ? 32'h0 : 32'hA5000000 | 32'(i * 7));
      check($sformatf("fill_rd2_%0d", i), read_data2, i == 31 ? 32'h0 : 32'hA5000000 | 32'((31 - i) * 7));
    end
    // outputs must hold between edges
    step(0, 1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd0);
    reg_write = 0; read_reg1 = 5'd0; read_reg2 = 5'd29;
    #3;
    check("hold_rd1", read_data1, 32'hCAFEF00D);
    check("hold_rd2", read_data2, 32'h0);
    for (int n = 0; n < 600; n++) begin
      logic rst, rw;
      logic [4:0] wr, r1, r2;
      rst = $urandom_range(0, 59) == 0;
      rw = $urandom_range(0, 2) != 0;
      wr = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      r1 = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      r2 = $urandom_range(0, 4) == 0 ? wr : 5'($urandom_range(0, 31));
      step(rst, rw, wr, $urandom, r1, r2);
      check($sformatf("rand%0d_rd1", n), read_data1, m1);
      check($sformatf("rand%0d_rd2", n), read_data2, m2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
